dmem_wait_ctrl: RTL and testbench
=================================

Name: dmem_wait_ctrl

Overview:
- Data-memory controller directly downstream of the multi-cycle core's data-memory port.
- Accepts one load/store request at a time and drives a single-port synchronous SRAM, inserting WAIT_CYCLES programmable wait states.
- Returns a one-cycle dmem_ready_o pulse with read data, or an error flag for out-of-range addresses.
- The core's memory-stall logic relies on this ready pulse.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the core-side request.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- WAIT_CYCLES, 2, wait states between acceptance and SRAM access (0 is legal).
- MEM_DEPTH_WORDS, 1024, SRAM depth in words; SRAM word-address width is $clog2(MEM_DEPTH_WORDS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dmem_addr_i  in  ADDR_WIDTH  byte address.
- dmem_wdata_i  in  DATA_WIDTH  store data.
- dmem_wstrb_i  in  DATA_WIDTH/8  store byte enables.
- dmem_write_i  in  1  store request.
- dmem_read_i  in  1  load request.
- dmem_rdata_o  out  DATA_WIDTH  load data.
- dmem_ready_o  out  1  one-cycle completion pulse.
- dmem_err_o  out  1  error qualifier, valid only while dmem_ready_o=1.
- mem_en_o  out  1  SRAM enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  $clog2(MEM_DEPTH_WORDS)  SRAM word address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after mem_en_o with mem_we_o=0.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE; the wait counter and all request registers clear.
  - dmem_ready_o, dmem_err_o, mem_en_o and mem_we_o are 0.
  - dmem_rdata_o, mem_addr_o, mem_wdata_o and mem_be_o are 0.
- Reset asserted mid-transaction aborts it: no ready pulse, no SRAM write after rst rises. The first request after rst falls is accepted normally.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - A request is accepted when dmem_read_i or dmem_write_i is high on a rising edge.
  - On acceptance, register addr, wdata, wstrb, the op type, and err_r.
  - err_r=1 if dmem_addr_i >= MEM_DEPTH_WORDS*4, or if read and write are both high.
  - Next state: RESP if err_r; otherwise WAIT if WAIT_CYCLES>0, else ACCESS.
  - Counter loads WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each cycle; move to ACCESS when it reaches 0.
  - Total time in WAIT is exactly WAIT_CYCLES cycles.
- ACCESS (one cycle):
  - mem_en_o=1; mem_addr_o = addr_r[ADDR_WIDTH-1:2] truncated to the SRAM address width; mem_wdata_o = wdata_r; mem_be_o = wstrb_r.
  - mem_we_o=1 for a store.
  - A store with wstrb_r=0 drives mem_en_o=0 (no access) but still completes.
  - Next state: RESP.
- RESP (one cycle):
  - dmem_ready_o=1; dmem_err_o = err_r.
  - Load without error: dmem_rdata_o = mem_rdata_i, combinational pass-through, and the value is captured into rdata_r.
  - Store or error: dmem_rdata_o = rdata_r for a store; 0 for an error.
  - Next state: IDLE.
- Outside RESP: dmem_rdata_o = rdata_r, which holds the last successful load data.
- Latency, acceptance edge to ready-high cycle:
  - Normal request: WAIT_CYCLES+2 cycles, i.e. 4 at the default.
  - Error request: 1 cycle.
- Requests present in WAIT, ACCESS or RESP are ignored. The core holds its request until it sees ready, and a request still high in the cycle after RESP is accepted as a new transaction. The core must drop its request in the ready cycle to avoid re-issue.
- The SRAM outputs are registered decodes of the state, so no combinational path exists from dmem_*_i to mem_*_o.
- Address bits [1:0] are ignored; byte selection is done by the core and mem_be_o.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - the state enum dmem_ctrl_state_e {IDLE, WAIT, ACCESS, RESP};
  - a function computing the wait-counter width, $clog2(WAIT_CYCLES+1), minimum 1.
- Single module, no sub-module. The SRAM itself is external; the bench uses a behavioural synchronous-read SRAM model.

Test Plan:
- Store then load, default params: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF.
  - Expect mem_we_o pulse at cycle +3 with mem_addr_o=4, dmem_ready_o at +4.
  - Then a read of 0x10 gives dmem_ready_o at +4 with dmem_rdata_o=0xDEADBEEF.
- Partial store: store 0x000000AA with wstrb 0x1 onto word 0x11223344 at addr 0x20. Readback returns 0x112233AA.
- Error path: read addr 0x1000 (= MEM_DEPTH_WORDS*4) gives ready at +1 with dmem_err_o=1, dmem_rdata_o=0, and mem_en_o never high. Read and write both high gives the same response.
- WAIT_CYCLES=0: read ready at +2. Back-to-back reads with request held through ready and the next request issued after it: second accepted the cycle after RESP, no overlap.
- Reset mid-op: assert rst during WAIT of a store.
  - No mem_en_o and no ready pulse; all outputs read 0.
  - After release, a read of the same address returns the old SRAM contents.
- Zero-strobe store with wstrb=0: ready at +4, mem_en_o stays 0, and dmem_rdata_o still holds the prior load value.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and helpers for the data-memory wait-state controller
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_ctrl_state_e;

  // Width of the wait counter; never below one bit so WAIT_CYCLES=0 still elaborates.
  function automatic int wait_cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl.sv
// rtl/dmem_wait_ctrl.sv - single-request data-memory controller with programmable SRAM wait states
module dmem_wait_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WAIT_CYCLES     = 2,
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]              dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            dmem_wstrb_i,
  input  logic                               dmem_write_i,
  input  logic                               dmem_read_i,
  output logic [DATA_WIDTH-1:0]              dmem_rdata_o,
  output logic                               dmem_ready_o,
  output logic                               dmem_err_o,
  output logic                               mem_en_o,
  output logic                               mem_we_o,
  output logic [$clog2(MEM_DEPTH_WORDS)-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            mem_be_o,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam int CW = wait_cnt_width(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS * 4);
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  dmem_ctrl_state_e r_state;
  dmem_ctrl_state_e w_next;

  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BW-1:0]         r_wstrb;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_req;
  logic w_req_err;
  logic w_store_nop;

  assign w_req       = dmem_read_i | dmem_write_i;
  assign w_req_err   = ({1'b0, dmem_addr_i} >= ADDR_LIMIT) | (dmem_read_i & dmem_write_i);
  // A store with no byte lanes enabled completes without touching the SRAM.
  assign w_store_nop = r_write && (r_wstrb == '0);

  // SRAM-side address/data come straight from the request registers, never from the core inputs.
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_wstrb;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    w_next       = r_state;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    dmem_ready_o = 1'b0;
    dmem_err_o   = 1'b0;
    dmem_rdata_o = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_req_err)            w_next = RESP;
          else if (WAIT_CYCLES > 0) w_next = WAIT;
          else                      w_next = ACCESS;
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_next = ACCESS;
      end
      ACCESS: begin
        mem_en_o = !w_store_nop;
        mem_we_o = r_write && !w_store_nop;
        w_next   = RESP;
      end
      RESP: begin
        dmem_ready_o = 1'b1;
        dmem_err_o   = r_err;
        if (r_err)         dmem_rdata_o = '0;
        else if (!r_write) dmem_rdata_o = mem_rdata_i;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture, wait countdown and load-data retention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= dmem_addr_i[AW+1:2];
            r_wdata <= dmem_wdata_i;
            r_wstrb <= dmem_wstrb_i;
            r_write <= dmem_write_i;
            r_err   <= w_req_err;
            r_cnt   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        RESP: begin
          if (!r_err && !r_write) r_rdata <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb/tb_dmem_wait_ctrl.sv - directed scoreboard bench for dmem_wait_ctrl (default and zero-wait instances)
module tb_dmem_wait_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default parameters. Instance B: WAIT_CYCLES=0.
  logic [31:0] a_addr, a_wdata, a_rdata, a_mwdata, a_mrdata;
  logic [3:0]  a_wstrb, a_be;
  logic        a_wr, a_rd, a_ready, a_err, a_en, a_we;
  logic [9:0]  a_maddr;
  logic [31:0] b_addr, b_wdata, b_rdata, b_mwdata, b_mrdata;
  logic [3:0]  b_wstrb, b_be;
  logic        b_wr, b_rd, b_ready, b_err, b_en, b_we;
  logic [9:0]  b_maddr;

  dmem_wait_ctrl dut_a (
    .clk(clk), .rst(rst),
    .dmem_addr_i(a_addr), .dmem_wdata_i(a_wdata), .dmem_wstrb_i(a_wstrb),
    .dmem_write_i(a_wr), .dmem_read_i(a_rd),
    .dmem_rdata_o(a_rdata), .dmem_ready_o(a_ready), .dmem_err_o(a_err),
    .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwdata), .mem_be_o(a_be), .mem_rdata_i(a_mrdata)
  );

  dmem_wait_ctrl #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .dmem_addr_i(b_addr), .dmem_wdata_i(b_wdata), .dmem_wstrb_i(b_wstrb),
    .dmem_write_i(b_wr), .dmem_read_i(b_rd),
    .dmem_rdata_o(b_rdata), .dmem_ready_o(b_ready), .dmem_err_o(b_err),
    .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_be_o(b_be), .mem_rdata_i(b_mrdata)
  );

  // Behavioural synchronous-read SRAMs with byte enables.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        for (int i = 0; i < 4; i++)
          if (a_be[i]) mem_a[a_maddr][8*i +: 8] <= a_mwdata[8*i +: 8];
      end else begin
        a_mrdata <= mem_a[a_maddr];
      end
    end
  end

  always @(posedge clk) begin
    if (b_en) begin
      if (b_we) begin
        for (int i = 0; i < 4; i++)
          if (b_be[i]) mem_b[b_maddr][8*i +: 8] <= b_mwdata[8*i +: 8];
      end else begin
        b_mrdata <= mem_b[b_maddr];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? b_ready : a_ready;
  endfunction

  function automatic logic en(input bit s);
    return s ? b_en : a_en;
  endfunction

  task automatic drive(input bit s, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (s) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
    end
  endtask

  // One complete request: push expectation, hold request until ready, pop and compare.
  task automatic req(input string tag, input bit s, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input int lat, input logic [31:0] erd, input logic eerr, input bit exp_en,
                     output int we_cyc, output logic [9:0] we_addr);
    exp_t e;
    exp_t g;
    int   k;
    bit   seen_en;
    logic [31:0] got_rd;
    logic        got_err;
    e.rdata = erd; e.err = eerr; e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    drive(s, rd, wr, addr, wdata, wstrb);
    k = 0; seen_en = 0; we_cyc = 0; we_addr = '0;
    do begin
      @(negedge clk);
      k++;
      if (en(s)) seen_en = 1;
      if (!s && a_we) begin we_cyc = k; we_addr = a_maddr; end
    end while (!rdy(s) && k < 20);
    got_rd  = s ? b_rdata : a_rdata;
    got_err = s ? b_err : a_err;
    drive(s, 0, 0, '0, '0, '0);
    g = sb_q.pop_front();
    chk({tag, "_latency"}, k, g.lat);
    chk({tag, "_rdata"}, got_rd, g.rdata);
    chk({tag, "_err"}, {31'b0, got_err}, {31'b0, g.err});
    chk({tag, "_mem_en_seen"}, {31'b0, seen_en}, {31'b0, exp_en});
    @(negedge clk);
    chk({tag, "_ready_one_cycle"}, {31'b0, rdy(s)}, 32'd0);
  endtask

  int          wc;
  logic [9:0]  wa;
  int          k;
  bit          seen;
  exp_t        g;

  initial begin
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_b[4] = 32'h1111_1111;
    mem_b[5] = 32'h2222_2222;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, a_ready}, 0);
    chk("rst_err",   {31'b0, a_err}, 0);
    chk("rst_en",    {31'b0, a_en}, 0);
    chk("rst_we",    {31'b0, a_we}, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_addr",  {22'b0, a_maddr}, 0);
    chk("rst_wdata", a_mwdata, 0);
    chk("rst_be",    {28'b0, a_be}, 0);
    rst = 1'b0;

    // Store then load at the default wait count.
    req("st_full", 0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 4, 32'h0, 0, 1, wc, wa);
    chk("st_full_we_cycle", wc, 3);
    chk("st_full_we_addr", {22'b0, wa}, 4);
    req("ld_full", 0, 1, 0, 32'h10, 32'h0, 4'h0, 4, 32'hDEAD_BEEF, 0, 1, wc, wa);

    // Partial store merges into the existing word.
    req("st_base", 0, 0, 1, 32'h20, 32'h1122_3344, 4'hF, 4, 32'hDEAD_BEEF, 0, 1, wc, wa);
    req("st_byte", 0, 0, 1, 32'h20, 32'h0000_00AA, 4'h1, 4, 32'hDEAD_BEEF, 0, 1, wc, wa);
    chk("st_byte_we_addr", {22'b0, wa}, 8);
    req("ld_byte", 0, 1, 0, 32'h20, 32'h0, 4'h0, 4, 32'h1122_33AA, 0, 1, wc, wa);

    // Error responses: first out-of-range address, and simultaneous read+write.
    req("err_range", 0, 1, 0, 32'h1000, 32'h0, 4'h0, 1, 32'h0, 1, 0, wc, wa);
    req("err_rdwr", 0, 1, 1, 32'h10, 32'h5555_5555, 4'hF, 1, 32'h0, 1, 0, wc, wa);
    req("ld_after_err", 0, 1, 0, 32'hFFC, 32'h0, 4'h0, 4, 32'h0, 0, 1, wc, wa);

    // Zero-strobe store: completes, no SRAM access, holds last load data.
    req("ld_pre_nop", 0, 1, 0, 32'h20, 32'h0, 4'h0, 4, 32'h1122_33AA, 0, 1, wc, wa);
    req("st_nop", 0, 0, 1, 32'h10, 32'h0, 4'h0, 4, 32'h1122_33AA, 0, 0, wc, wa);
    req("ld_post_nop", 0, 1, 0, 32'h10, 32'h0, 4'h0, 4, 32'hDEAD_BEEF, 0, 1, wc, wa);

    // Reset during the WAIT phase of a store aborts it.
    req("st_old", 0, 0, 1, 32'h30, 32'hCAFE_F00D, 4'hF, 4, 32'hDEAD_BEEF, 0, 1, wc, wa);
    @(negedge clk);
    drive(0, 0, 1, 32'h30, 32'h5555_5555, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, a_ready}, 0);
    chk("midrst_en",    {31'b0, a_en}, 0);
    chk("midrst_rdata", a_rdata, 0);
    chk("midrst_wdata", a_mwdata, 0);
    chk("midrst_addr",  {22'b0, a_maddr}, 0);
    drive(0, 0, 0, '0, '0, '0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_en || a_ready || a_we) seen = 1;
    end
    chk("midrst_quiet", {31'b0, seen}, 0);
    rst = 1'b0;
    req("ld_after_rst", 0, 1, 0, 32'h30, 32'h0, 4'h0, 4, 32'hCAFE_F00D, 0, 1, wc, wa);

    // Zero wait states: single read latency.
    req("b_ld", 1, 1, 0, 32'h10, 32'h0, 4'h0, 2, 32'h1111_1111, 0, 1, wc, wa);

    // Zero wait states: request held through ready, next one accepted after RESP.
    g.rdata = 32'h2222_2222; g.err = 0; g.lat = 2; sb_q.push_back(g);
    g.rdata = 32'h1111_1111; g.err = 0; g.lat = 5; sb_q.push_back(g);
    @(negedge clk);
    drive(1, 1, 0, 32'h14, '0, '0);
    k = 0;
    do begin @(negedge clk); k++; end while (!b_ready && k < 20);
    g = sb_q.pop_front();
    chk("b2b_first_latency", k, g.lat);
    chk("b2b_first_rdata", b_rdata, g.rdata);
    drive(1, 1, 0, 32'h10, '0, '0);
    do begin @(negedge clk); k++; end while (!b_ready && k < 20);
    g = sb_q.pop_front();
    chk("b2b_second_latency", k, g.lat);
    chk("b2b_second_rdata", b_rdata, g.rdata);
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("b2b_ready_one_cycle", {31'b0, b_ready}, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
